// File: rtl/mem_access_ctrl.sv
// Load/store front-end for the 256x16 data memory: accepts one request at a time,
// owns the memory bus for ACCESS_CYCLES cycles and returns a registered response.
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int DATA_W        = 16,
  parameter int ADDR_W        = 8,
  parameter int ACCESS_CYCLES = 2   // legal range 1..15 (4-bit counter)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_ls,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_ls,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_en,
  output logic              mem_load_store,
  output logic [ADDR_W-1:0] mem_add,
  inout  wire  [DATA_W-1:0] mem_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_op_ls;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_mem_en;
  logic                r_resp_valid;
  logic                r_resp_ls;
  logic [DATA_W-1:0]   r_resp_rdata;

  state_t              w_state_next;
  logic [3:0]          w_cnt_next;
  logic                w_op_ls_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [DATA_W-1:0]   w_wdata_next;
  logic                w_mem_en_next;
  logic                w_resp_valid_next;
  logic                w_resp_ls_next;
  logic [DATA_W-1:0]   w_resp_rdata_next;

  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_bus_drive;

  assign w_req_fire  = req_valid & (r_state == ST_IDLE);
  assign w_resp_fire = r_resp_valid & resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_op_ls      <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mem_en     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_ls    <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_op_ls      <= w_op_ls_next;
      r_addr       <= w_addr_next;
      r_wdata      <= w_wdata_next;
      r_mem_en     <= w_mem_en_next;
      r_resp_valid <= w_resp_valid_next;
      r_resp_ls    <= w_resp_ls_next;
      r_resp_rdata <= w_resp_rdata_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_op_ls_next      = r_op_ls;
    w_addr_next       = r_addr;
    w_wdata_next      = r_wdata;
    w_mem_en_next     = r_mem_en;
    w_resp_valid_next = r_resp_valid;
    w_resp_ls_next    = r_resp_ls;
    w_resp_rdata_next = r_resp_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_req_fire) begin
          w_state_next  = ST_ACCESS;
          w_cnt_next    = CNT_INIT;
          w_op_ls_next  = req_ls;
          w_addr_next   = req_addr;
          w_wdata_next  = req_wdata;
          w_mem_en_next = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          // Final access edge: the memory has driven the bus for the full window.
          w_state_next      = ST_RESP;
          w_mem_en_next     = 1'b0;
          w_resp_valid_next = 1'b1;
          w_resp_ls_next    = r_op_ls;
          if (r_op_ls) begin
            w_resp_rdata_next = mem_data;
          end
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (w_resp_fire) begin
          w_state_next      = ST_IDLE;
          w_resp_valid_next = 1'b0;
        end
      end
      default: begin
        w_state_next      = ST_IDLE;
        w_mem_en_next     = 1'b0;
        w_resp_valid_next = 1'b0;
      end
    endcase
  end

  // Only stores drive the bus; the memory drives only on en & load_store, so no contention.
  assign w_bus_drive    = (r_state == ST_ACCESS) & ~r_op_ls;
  assign mem_data       = w_bus_drive ? r_wdata : {DATA_W{1'bz}};

  assign req_ready      = (r_state == ST_IDLE);
  assign mem_en         = r_mem_en;
  assign mem_load_store = (r_state == ST_ACCESS) ? r_op_ls : 1'b1;
  assign mem_add        = r_addr;
  assign resp_valid     = r_resp_valid;
  assign resp_ls        = r_resp_ls;
  assign resp_rdata     = r_resp_rdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 256x16 memory on the shared bus;
// a second instance built with ACCESS_CYCLES=1 covers the single-cycle access case.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
  localparam int DW = 16;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          req_valid, req_ready, req_ls;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_ls;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_ls;
  logic [AW-1:0] mem_add;
  wire  [DW-1:0] mem_data;

  logic          req_valid1, req_ready1, req_ls1;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata1;
  logic          resp_valid1, resp_ready1, resp_ls1;
  logic [DW-1:0] resp_rdata1;
  logic          mem_en1, mem_ls1;
  logic [AW-1:0] mem_add1;
  wire  [DW-1:0] mem_data1;

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_ls(req_ls),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ls(resp_ls),
    .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_load_store(mem_ls), .mem_add(mem_add), .mem_data(mem_data)
  );

  mem_access_ctrl #(.DATA_W(DW), .ADDR_W(AW), .ACCESS_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_ls(req_ls1),
    .req_addr(req_addr1), .req_wdata(req_wdata1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1), .resp_ls(resp_ls1),
    .resp_rdata(resp_rdata1),
    .mem_en(mem_en1), .mem_load_store(mem_ls1), .mem_add(mem_add1), .mem_data(mem_data1)
  );

  // Behavioural memories: combinational read drive, write on the clock edge.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem1 [256];

  assign mem_data  = (mem_en  && mem_ls)  ? mem0[mem_add]  : {DW{1'bz}};
  assign mem_data1 = (mem_en1 && mem_ls1) ? mem1[mem_add1] : {DW{1'bz}};

  always @(posedge clk) begin
    if (mem_en && !mem_ls) mem0[mem_add] <= mem_data;
    if (mem_en1 && !mem_ls1) mem1[mem_add1] <= mem_data1;
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem0[i] <= DW'(i);
      mem1[i] <= DW'(i);
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic          rel;
  logic          op;
  logic [DW-1:0] wd;
  logic [DW-1:0] last_store;
  logic [DW-1:0] exp_rdata;
  int            waited;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_ls = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    req_valid1 = 1'b0; req_ls1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; resp_ready1 = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_ls", resp_ls, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_ls", mem_ls, 1);
    check("rst_mem_add", mem_add, 0);
    rel = (mem_data === 16'hzzzz);
    check("rst_bus_released", rel, 1);
    rst_n = 1'b1;
    tick();

    // Load 0x05 with resp_ready held high
    req_valid = 1'b1; req_ls = 1'b1; req_addr = 8'h05;
    tick();
    req_valid = 1'b0; req_addr = 8'h00;
    check("ld05_e0_mem_en", mem_en, 1);
    check("ld05_e0_mem_ls", mem_ls, 1);
    check("ld05_e0_mem_add", mem_add, 8'h05);
    check("ld05_e0_req_ready", req_ready, 0);
    check("ld05_e0_bus", mem_data, 16'h0005);
    tick();
    check("ld05_e1_mem_en", mem_en, 1);
    check("ld05_e1_resp_valid", resp_valid, 0);
    tick();
    check("ld05_e2_mem_en", mem_en, 0);
    check("ld05_e2_resp_valid", resp_valid, 1);
    check("ld05_e2_resp_ls", resp_ls, 1);
    check("ld05_e2_resp_rdata", resp_rdata, 16'h0005);
    check("ld05_e2_req_ready", req_ready, 0);
    tick();
    check("ld05_e3_resp_valid", resp_valid, 0);
    check("ld05_e3_req_ready", req_ready, 1);

    // Store 0xBEEF to 0x10 (request fields scrambled right after acceptance)
    req_valid = 1'b1; req_ls = 1'b0; req_addr = 8'h10; req_wdata = 16'hBEEF;
    tick();
    req_valid = 1'b0; req_ls = 1'b1; req_addr = 8'h00; req_wdata = 16'h0000;
    check("st10_e0_mem_en", mem_en, 1);
    check("st10_e0_mem_ls", mem_ls, 0);
    check("st10_e0_mem_add", mem_add, 8'h10);
    check("st10_e0_bus", mem_data, 16'hBEEF);
    tick();
    check("st10_e1_bus", mem_data, 16'hBEEF);
    check("st10_e1_mem_ls", mem_ls, 0);
    tick();
    check("st10_e2_resp_valid", resp_valid, 1);
    check("st10_e2_resp_ls", resp_ls, 0);
    check("st10_e2_resp_rdata_held", resp_rdata, 16'h0005);
    check("st10_e2_mem_en", mem_en, 0);
    check("st10_e2_mem_ls", mem_ls, 1);
    rel = (mem_data === 16'hzzzz);
    check("st10_e2_bus_released", rel, 1);
    tick();

    // Load 0x10 back; the controller must leave the bus to the memory
    req_valid = 1'b1; req_ls = 1'b1; req_addr = 8'h10;
    tick();
    req_valid = 1'b0;
    check("ld10_e0_bus", mem_data, 16'hBEEF);
    tick();
    check("ld10_e1_bus", mem_data, 16'hBEEF);
    tick();
    check("ld10_resp_rdata", resp_rdata, 16'hBEEF);
    check("ld10_resp_ls", resp_ls, 1);
    tick();

    // Load 0x20 with a stalled consumer; a request during RESP must be ignored
    resp_ready = 1'b0;
    req_valid = 1'b1; req_ls = 1'b1; req_addr = 8'h20;
    tick();
    req_ls = 1'b0; req_addr = 8'h33; req_wdata = 16'h1234;
    tick(); tick();
    check("ld20_resp_valid", resp_valid, 1);
    check("ld20_resp_rdata", resp_rdata, 16'h0020);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("ld20_stall_resp_valid", resp_valid, 1);
      check("ld20_stall_resp_rdata", resp_rdata, 16'h0020);
      check("ld20_stall_req_ready", req_ready, 0);
      check("ld20_stall_mem_en", mem_en, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    check("ld20_release_resp_valid", resp_valid, 0);
    check("ld20_release_req_ready", req_ready, 1);
    check("ld20_release_mem_en", mem_en, 0);

    // Continuous req_valid, alternating store/load to 0xFF
    exp_rdata = 16'h0020;
    last_store = 16'h0000;
    req_valid = 1'b1; req_addr = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      op = k[0];
      wd = (k == 0) ? 16'hA5A5 : 16'h5A5A;
      req_ls = op; req_wdata = wd;
      waited = 0;
      while (!req_ready && waited < 10) begin
        tick();
        waited++;
      end
      check("b2b_accept_wait", waited, 0);
      tick();
      req_ls = ~op; req_wdata = 16'h0000;
      if (!op) last_store = wd;
      else exp_rdata = last_store;
      check("b2b_e0_mem_en", mem_en, 1);
      check("b2b_e0_mem_add", mem_add, 8'hFF);
      check("b2b_e0_mem_ls", mem_ls, op);
      check("b2b_e0_bus", mem_data, last_store);
      tick();
      check("b2b_e1_mem_en", mem_en, 1);
      check("b2b_e1_mem_add", mem_add, 8'hFF);
      check("b2b_e1_mem_ls", mem_ls, op);
      tick();
      check("b2b_resp_valid", resp_valid, 1);
      check("b2b_resp_ls", resp_ls, op);
      check("b2b_resp_rdata", resp_rdata, exp_rdata);
      tick();
      check("b2b_idle_resp_valid", resp_valid, 0);
      check("b2b_idle_req_ready", req_ready, 1);
    end
    req_valid = 1'b0;
    tick();

    // Reset asserted in the second ACCESS cycle of a store
    req_valid = 1'b1; req_ls = 1'b0; req_addr = 8'h40; req_wdata = 16'h1111;
    tick();
    req_valid = 1'b0;
    tick();
    check("rstmid_pre_mem_en", mem_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_mem_en", mem_en, 0);
    check("rstmid_mem_ls", mem_ls, 1);
    rel = (mem_data === 16'hzzzz);
    check("rstmid_bus_released", rel, 1);
    check("rstmid_resp_valid", resp_valid, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    check("rstmid_after_resp_valid", resp_valid, 0);
    check("rstmid_after_req_ready", req_ready, 1);
    check("rstmid_after_mem_en", mem_en, 0);

    // ACCESS_CYCLES=1 instance: load 0x7F
    req_valid1 = 1'b1; req_ls1 = 1'b1; req_addr1 = 8'h7F;
    tick();
    req_valid1 = 1'b0;
    check("ac1_e0_mem_en", mem_en1, 1);
    check("ac1_e0_resp_valid", resp_valid1, 0);
    check("ac1_e0_bus", mem_data1, 16'h007F);
    tick();
    check("ac1_e1_mem_en", mem_en1, 0);
    check("ac1_e1_resp_valid", resp_valid1, 1);
    check("ac1_e1_resp_ls", resp_ls1, 1);
    check("ac1_e1_resp_rdata", resp_rdata1, 16'h007F);
    tick();
    check("ac1_e2_resp_valid", resp_valid1, 0);
    check("ac1_e2_req_ready", req_ready1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
